// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button front end.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } debounce_state_t;

  localparam int CLK_HZ             = 100_000_000;
  // 5 ms of stability at the board clock.
  localparam int DEB_CYCLES_DEFAULT = CLK_HZ / 200;

  localparam int NUM_BTN   = 2;
  localparam int BTN_PAUSE = 0;
  localparam int BTN_CLR   = 1;

  function automatic int deb_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/stopwatch_button_ctrl_if.sv
// Board-side button inputs and the pause/clear controls sent to the counter logic.
interface stopwatch_button_ctrl_if;

  logic btn_pause_raw;
  logic btn_clr_raw;
  logic pause;
  logic clr_pulse;

  modport master (
    output btn_pause_raw,
    output btn_clr_raw,
    input  pause,
    input  clr_pulse
  );

  modport slave (
    input  btn_pause_raw,
    input  btn_clr_raw,
    output pause,
    output clr_pulse
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce FSM; emits a one-cycle press strobe per
// accepted press of a raw push-button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int              CNT_W    = deb_cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic            s1_reg;
  logic            s2_reg;
  debounce_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic            press_reg, press_next;

  // Starting in REL_WAIT means a button held through reset reads as HELD, not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      state_reg <= REL_WAIT;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      s1_reg    <= raw;
      s2_reg    <= s1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s2_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_reg) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2_reg) begin
          state_next = REL_WAIT;
          cnt_next   = '0;
        end
      end
      REL_WAIT: begin
        if (s2_reg) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = REL_WAIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign press = press_reg;

endmodule

// File: rtl/stopwatch_button_ctrl.sv
// Pause-toggle / clear-pulse front end for the stopwatch counter.
// Build option: define CLEAR_PAUSE_EN to make a clear press also stop the watch.
module stopwatch_button_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter bit PAUSE_INIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  stopwatch_button_ctrl_if.slave  bus
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;

  assign raw[BTN_PAUSE] = bus.btn_pause_raw;
  assign raw[BTN_CLR]   = bus.btn_clr_raw;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  logic pause_reg, pause_next;
  logic clr_pulse_reg, clr_pulse_next;

  // Clear wins over a coincident pause strobe.
  always_comb begin
    pause_next     = pause_reg;
    clr_pulse_next = press[BTN_CLR];
    if (press[BTN_CLR]) begin
`ifdef CLEAR_PAUSE_EN
      pause_next = 1'b1;
`else
      pause_next = pause_reg;
`endif
    end else if (press[BTN_PAUSE]) begin
      pause_next = ~pause_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_reg     <= PAUSE_INIT;
      clr_pulse_reg <= 1'b0;
    end else begin
      pause_reg     <= pause_next;
      clr_pulse_reg <= clr_pulse_next;
    end
  end

  assign bus.pause     = pause_reg;
  assign bus.clr_pulse = clr_pulse_reg;

endmodule
